// File: rtl/ast_pkg.sv
// ast_pkg: shared types, defaults and helpers for the Avalon-ST symbol adapters.
//   ser_state_e  : serializer state (IDLE = holding register empty, SHIFT = beat in flight)
//   sym_count()  : number of symbols to emit from a beat, with empty clamped
//   sym_select() : pick symbol idx out of a beat, MSB-first or LSB-first
package ast_pkg;

   localparam int unsigned DEF_DATABITS_PER_SYMBOL = 8;
   localparam int unsigned DEF_SYMBOLS_PER_BEAT    = 4;
   localparam int unsigned DEF_WIDTH   = DEF_DATABITS_PER_SYMBOL * DEF_SYMBOLS_PER_BEAT;
   localparam int unsigned DEF_EMPTY_W = (DEF_SYMBOLS_PER_BEAT > 2) ? $clog2(DEF_SYMBOLS_PER_BEAT) : 1;

   // Upper bounds for the width-generic helper functions.
   localparam int unsigned MAX_SYMBOLS_PER_BEAT = 16;
   localparam int unsigned MAX_DATABITS         = 64;
   localparam int unsigned MAX_WIDTH            = MAX_SYMBOLS_PER_BEAT * MAX_DATABITS;

   typedef enum logic {S_IDLE, S_SHIFT} ser_state_e;

   // Symbols carried by a beat. An oversized empty still leaves one symbol.
   function automatic int unsigned sym_count(input logic eop, input int unsigned empty,
                                             input int unsigned spb);
      int unsigned e;
      if (!eop) return spb;
      e = (empty >= spb) ? spb - 1 : empty;
      return spb - e;
   endfunction

   // Symbol idx of beat; idx 0 is the MSB symbol when msb_first=1.
   function automatic logic [MAX_DATABITS-1:0] sym_select(input logic [MAX_WIDTH-1:0] beat,
                                                         input int unsigned idx,
                                                         input int unsigned spb,
                                                         input int unsigned dbps,
                                                         input logic msb_first);
      int unsigned pos;
      pos = msb_first ? (spb - 1 - idx) : idx;
      return MAX_DATABITS'(beat >> (pos * dbps));
   endfunction

endpackage

// File: rtl/ast_symbol_mux.sv
// ast_symbol_mux: combinational indexed symbol select with order control.
//   beat_i : SPB*DBPS-bit beat
//   idx_i  : symbol index 0..SPB-1 in emission order
//   sym_o  : selected DBPS-bit symbol
module ast_symbol_mux
   import ast_pkg::*;
#(
   parameter int unsigned DBPS      = DEF_DATABITS_PER_SYMBOL,
   parameter int unsigned SPB       = DEF_SYMBOLS_PER_BEAT,
   parameter bit          MSB_FIRST = 1'b1,
   parameter int unsigned IDX_W     = $clog2(SPB)
) (
   input  logic [SPB*DBPS-1:0] beat_i,
   input  logic [IDX_W-1:0]    idx_i,
   output logic [DBPS-1:0]     sym_o
);

   logic [MAX_DATABITS-1:0] sel;

   always_comb begin
      sel   = sym_select(MAX_WIDTH'(beat_i), 32'(idx_i), SPB, DBPS, MSB_FIRST);
      sym_o = DBPS'(sel);
   end

endmodule

// File: rtl/ast_beat_serializer.sv
// ast_beat_serializer: Avalon-ST beat-to-symbol width adapter.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   snk_*               : multi-symbol beat sink (data, valid, ready, sop, eop, empty)
//   src_*               : single-symbol source (data, valid, ready, sop, eop), readyLatency 0
// One beat is held and shifted out one symbol per clock; a new beat is taken on the
// cycle the last symbol is consumed, so back-to-back beats have no bubble.
module ast_beat_serializer
   import ast_pkg::*;
#(
   parameter int unsigned DATABITS_PER_SYMBOL             = 8,
   parameter int unsigned SYMBOLS_PER_BEAT                = 4,
   parameter bit          FIRST_SYMBOL_IN_HIGH_ORDER_BITS = 1'b1,
   parameter int unsigned WIDTH   = SYMBOLS_PER_BEAT * DATABITS_PER_SYMBOL,
   parameter int unsigned EMPTY_W = (SYMBOLS_PER_BEAT > 2) ? $clog2(SYMBOLS_PER_BEAT) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [WIDTH-1:0]               snk_data_i,
   input  logic                           snk_valid_i,
   output logic                           snk_ready_o,
   input  logic                           snk_sop_i,
   input  logic                           snk_eop_i,
   input  logic [EMPTY_W-1:0]             snk_empty_i,
   output logic [DATABITS_PER_SYMBOL-1:0] src_data_o,
   output logic                           src_valid_o,
   input  logic                           src_ready_i,
   output logic                           src_sop_o,
   output logic                           src_eop_o
);

   localparam int unsigned IDX_W = $clog2(SYMBOLS_PER_BEAT);
   localparam int unsigned CNT_W = $clog2(SYMBOLS_PER_BEAT + 1);

   ser_state_e        state_q, state_d;
   logic [WIDTH-1:0]  beat_q, beat_d;
   logic              sop_q, sop_d;
   logic              eop_q, eop_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   logic last, accept, out_hs;

   assign last   = (state_q == S_SHIFT) && (CNT_W'(idx_q) == cnt_q - CNT_W'(1));
   // Ready is a function of state and src_ready_i only, never of snk_valid_i.
   assign snk_ready_o = !rst_i && ((state_q == S_IDLE) || (last && src_ready_i));
   assign accept      = snk_valid_i && snk_ready_o;
   assign src_valid_o = (state_q == S_SHIFT);
   assign out_hs      = src_valid_o && src_ready_i;
   assign src_sop_o   = src_valid_o && sop_q && (idx_q == '0);
   assign src_eop_o   = src_valid_o && eop_q && last;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      sop_d   = sop_q;
      eop_d   = eop_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      if (accept) begin
         // Covers both the idle load and the reload on the final symbol.
         state_d = S_SHIFT;
         beat_d  = snk_data_i;
         sop_d   = snk_sop_i;
         eop_d   = snk_eop_i;
         cnt_d   = CNT_W'(sym_count(snk_eop_i, 32'(snk_empty_i), SYMBOLS_PER_BEAT));
         idx_d   = '0;
      end else if (out_hs) begin
         if (last) begin
            state_d = S_IDLE;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   ast_symbol_mux #(
      .DBPS      (DATABITS_PER_SYMBOL),
      .SPB       (SYMBOLS_PER_BEAT),
      .MSB_FIRST (FIRST_SYMBOL_IN_HIGH_ORDER_BITS),
      .IDX_W     (IDX_W)
   ) u_mux (
      .beat_i (beat_q),
      .idx_i  (idx_q),
      .sym_o  (src_data_o)
   );

endmodule
